// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

   // Loader FSM states.
   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      WRITE,
      DONE,
      ERR
   } state_e;

   // The instruction memory is word addressed on addr[31:2].
   localparam int WORD_BYTES = 4;
   localparam int ADDR_SHIFT = 2;

   // Byte address of a given word index.
   function automatic logic [31:0] word_addr(input logic [31:0] idx);
      return idx << ADDR_SHIFT;
   endfunction

endpackage : imem_loader_pkg

// File: rtl/imem_loader_byte_packer.sv
// Assembles four stream bytes into a little-endian 32-bit word.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear_i,
   input  logic        push_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_next_o,
   output logic        full_o
);

   logic [1:0]  idx_q;
   logic [31:0] word_q;

   // Word as it will look once the current byte is inserted at its lane.
   always_comb begin
      word_next_o = word_q;
      word_next_o[{idx_q, 3'b000} +: 8] = byte_i;
   end

   // This push completes the word (last byte lane).
   assign full_o = push_i && (idx_q == 2'(WORD_BYTES - 1));

   // Byte index and partial word; clear discards any partial word.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         idx_q  <= '0;
         word_q <= '0;
      end else if (push_i) begin
         idx_q  <= idx_q + 2'd1;
         word_q <= word_next_o;
      end
   end

endmodule : imem_loader_byte_packer

// File: rtl/imem_loader.sv
// Program loader: byte stream in, header-counted words written to instruction memory.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        cpu_hold
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   word_idx_q, word_idx_d;
   logic [7:0]         hdr_lo_q, hdr_lo_d;
   logic               hdr_idx_q, hdr_idx_d;
   logic [31:0]        mem_addr_q, mem_addr_d;
   logic [31:0]        mem_wdata_q, mem_wdata_d;

   logic               xfer;
   logic               start_go;
   logic               pk_push;
   logic               pk_full;
   logic [31:0]        pk_word_next;
   logic [CNT_W-1:0]   hdr_n;

   assign byte_ready = (state_q == HDR) || (state_q == DATA);
   assign busy       = (state_q == HDR) || (state_q == DATA) || (state_q == WRITE);
   assign done       = (state_q == DONE);
   assign err        = (state_q == ERR);
   assign cpu_hold   = (state_q != DONE);
   // A synchronous reset in the WRITE cycle must still suppress the strobe.
   assign mem_we     = (state_q == WRITE) && !rst;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

   assign xfer     = byte_valid && byte_ready;
   assign start_go = start && !busy;
   assign pk_push  = xfer && (state_q == DATA);
   assign hdr_n    = CNT_W'({byte_in, hdr_lo_q});

   imem_loader_byte_packer u_packer (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (start_go),
      .push_i      (pk_push),
      .byte_i      (byte_in),
      .word_next_o (pk_word_next),
      .full_o      (pk_full)
   );

   // Next-state, counter and write-port register updates.
   // NOTE: every signal gets its default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      word_idx_d  = word_idx_q;
      hdr_lo_d    = hdr_lo_q;
      hdr_idx_d   = hdr_idx_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      unique case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d    = HDR;
               count_d    = '0;
               word_idx_d = '0;
               hdr_idx_d  = 1'b0;
               mem_addr_d = '0;
            end
         end
         HDR: begin
            if (abort) begin
               state_d = ERR;
            end else if (xfer) begin
               if (!hdr_idx_q) begin
                  hdr_lo_d  = byte_in;
                  hdr_idx_d = 1'b1;
               end else begin
                  count_d = hdr_n;
                  if (hdr_n == '0) begin
                     state_d = DONE;
                  end else if (hdr_n > CNT_W'(DEPTH)) begin
                     state_d = ERR;
                  end else begin
                     state_d = DATA;
                  end
               end
            end
         end
         DATA: begin
            if (abort) begin
               state_d = ERR;
            end else if (pk_full) begin
               mem_wdata_d = pk_word_next;
               mem_addr_d  = word_addr(32'(word_idx_q));
               state_d     = WRITE;
            end
         end
         WRITE: begin
            word_idx_d = word_idx_q + CNT_W'(1);
            if (abort) begin
               state_d = ERR;
            end else if (word_idx_q + CNT_W'(1) == count_q) begin
               state_d = DONE;
            end else begin
               state_d = DATA;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         word_idx_q  <= '0;
         hdr_lo_q    <= '0;
         hdr_idx_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         word_idx_q  <= word_idx_d;
         hdr_lo_q    <= hdr_lo_d;
         hdr_idx_q   <= hdr_idx_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic        cpu_hold;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          last_hs  = -10;
   logic [31:0] act_addr[$];
   logic [31:0] act_data[$];
   int          act_cyc[$];

   imem_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .cpu_hold   (cpu_hold)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Write log; each write must follow the last byte handshake by one cycle.
   always @(negedge clk) begin
      if (byte_valid && byte_ready) last_hs = cyc;
      if (mem_we) begin
         act_addr.push_back(mem_addr);
         act_data.push_back(mem_wdata);
         act_cyc.push_back(cyc);
         check("we_latency", 32'(cyc), 32'(last_hs + 1));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      act_addr.delete();
      act_data.delete();
      act_cyc.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input bit gaps);
      int g;
      int t;
      if (gaps) begin
         g = int'($urandom_range(0, 3));
         byte_valid = 1'b0;
         repeat (g) tick();
      end
      byte_in    = b;
      byte_valid = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         if (byte_ready) break;
         t++;
         if (t > 50) begin
            check("ready_timeout", 32'd0, 32'd1);
            break;
         end
      end
      tick();
      if (gaps) byte_valid = 1'b0;
   endtask

   task automatic send_hdr(input logic [15:0] n, input bit gaps);
      send(n[7:0], gaps);
      send(n[15:8], gaps);
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int k = 0; k < 4; k++) send(w[8*k +: 8], gaps);
   endtask

   task automatic wait_end(input string tag);
      int t;
      byte_valid = 1'b0;
      t = 0;
      forever begin
         @(negedge clk);
         if (done || err) break;
         t++;
         if (t > 200) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            break;
         end
      end
      tick();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"},    32'(byte_ready), 32'd0);
      check({tag, "_we"},       32'(mem_we),     32'd0);
      check({tag, "_addr"},     mem_addr,        32'd0);
      check({tag, "_wdata"},    mem_wdata,       32'd0);
      check({tag, "_busy"},     32'(busy),       32'd0);
      check({tag, "_done"},     32'(done),       32'd0);
      check({tag, "_err"},      32'(err),        32'd0);
      check({tag, "_cpu_hold"}, 32'(cpu_hold),   32'd1);
   endtask

   function automatic logic [31:0] full_word(input int i);
      return 32'hA5C3_0000 ^ (32'(i) * 32'h0101_0101);
   endfunction

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_reset_vals("rst");

      // Normal load, byte_valid held high.
      clear_log();
      pulse_start();
      send_hdr(16'd2, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b0);
      send_word(32'h1234_5678, 1'b0);
      wait_end("norm");
      check("norm_nwr", 32'(act_addr.size()), 32'd2);
      if (act_addr.size() == 2) begin
         check("norm_a0", act_addr[0], 32'h0);
         check("norm_d0", act_data[0], 32'hDEAD_BEEF);
         check("norm_a1", act_addr[1], 32'h4);
         check("norm_d1", act_data[1], 32'h1234_5678);
         check("norm_rate", 32'(act_cyc[1] - act_cyc[0]), 32'd5);
      end
      check("norm_done", 32'(done), 32'd1);
      check("norm_hold", 32'(cpu_hold), 32'd0);
      check("norm_addr_hold", mem_addr, 32'h4);
      check("norm_data_hold", mem_wdata, 32'h1234_5678);

      // Zero-length program.
      clear_log();
      pulse_start();
      check("zero_hold_reassert", 32'(cpu_hold), 32'd1);
      check("zero_busy", 32'(busy), 32'd1);
      send_hdr(16'd0, 1'b0);
      wait_end("zero");
      check("zero_nwr", 32'(act_addr.size()), 32'd0);
      check("zero_done", 32'(done), 32'd1);
      check("zero_hold", 32'(cpu_hold), 32'd0);

      // Oversize header; extra bytes stay offered but unconsumed.
      clear_log();
      pulse_start();
      send_hdr(16'h0041, 1'b0);
      byte_in = 8'h77;
      repeat (4) tick();
      check("over_err", 32'(err), 32'd1);
      check("over_ready", 32'(byte_ready), 32'd0);
      check("over_hold", 32'(cpu_hold), 32'd1);
      check("over_done", 32'(done), 32'd0);
      check("over_nwr", 32'(act_addr.size()), 32'd0);
      byte_valid = 1'b0;

      // Gapped stream, one word.
      clear_log();
      pulse_start();
      send_hdr(16'd1, 1'b1);
      send_word(32'hCAFE_F00D, 1'b1);
      wait_end("gap");
      check("gap_nwr", 32'(act_addr.size()), 32'd1);
      if (act_addr.size() == 1) begin
         check("gap_a0", act_addr[0], 32'h0);
         check("gap_d0", act_data[0], 32'hCAFE_F00D);
      end
      check("gap_done", 32'(done), 32'd1);

      // Abort after six data bytes, then a clean reload.
      clear_log();
      pulse_start();
      send_hdr(16'd3, 1'b0);
      send_word(32'h1122_3344, 1'b0);
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      byte_valid = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_err", 32'(err), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      repeat (3) tick();
      check("abort_nwr", 32'(act_addr.size()), 32'd1);
      if (act_addr.size() == 1) begin
         check("abort_a0", act_addr[0], 32'h0);
         check("abort_d0", act_data[0], 32'h1122_3344);
      end
      pulse_start();
      check("reload_err_clr", 32'(err), 32'd0);
      send_hdr(16'd1, 1'b0);
      send_word(32'h5566_7788, 1'b0);
      wait_end("reload");
      check("reload_nwr", 32'(act_addr.size()), 32'd2);
      if (act_addr.size() == 2) begin
         check("reload_a", act_addr[1], 32'h0);
         check("reload_d", act_data[1], 32'h5566_7788);
      end
      check("reload_done", 32'(done), 32'd1);

      // Reset during WRITE of word 1.
      clear_log();
      pulse_start();
      send_hdr(16'd2, 1'b0);
      send_word(32'h0102_0304, 1'b0);
      send_word(32'h0506_0708, 1'b0);
      byte_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("rstw_we_gated", 32'(mem_we), 32'd0);
      tick();
      rst = 1'b0;
      check_reset_vals("rstw");
      check("rstw_nwr", 32'(act_addr.size()), 32'd1);

      // Full depth: 64 words, last at 0xFC.
      clear_log();
      pulse_start();
      send_hdr(16'd64, 1'b0);
      for (int i = 0; i < 64; i++) send_word(full_word(i), 1'b0);
      wait_end("full");
      check("full_nwr", 32'(act_addr.size()), 32'd64);
      if (act_addr.size() == 64) begin
         for (int i = 0; i < 64; i++) begin
            check("full_addr", act_addr[i], 32'(4 * i));
            check("full_data", act_data[i], full_word(i));
         end
         check("full_last", act_addr[63], 32'h0000_00FC);
      end
      check("full_done", 32'(done), 32'd1);
      check("full_err", 32'(err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_imem_loader
